muldiv_unit: RTL



---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: data word, multiply/divide opcodes and FSM states
package cpu_types_pkg;
  localparam int WORD_W       = 32;
  localparam int MULDIV_ITERS = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;
endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - bundle of multiply/divide unit request and result signals
interface muldiv_if;
  import cpu_types_pkg::*;

  logic       start;
  muldiv_op_t md_op;
  word_t      port_a;
  word_t      port_b;
  logic       busy;
  logic       done;
  word_t      hi;
  word_t      lo;
  logic       div_zero;
  logic       unsupported;

  modport muldiv (
    input  start, md_op, port_a, port_b,
    output busy, done, hi, lo, div_zero, unsupported
  );

  modport tb (
    output start, md_op, port_a, port_b,
    input  busy, done, hi, lo, div_zero, unsupported
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit MULT/MULTU/DIV/DIVU unit holding results in HI/LO
// Divide datapath is built only when MULDIV_DIVIDE_EN is defined.
module muldiv_unit
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       start,
  input  muldiv_op_t md_op,
  input  word_t      port_a,
  input  word_t      port_b,
  output logic       busy,
  output logic       done,
  output word_t      hi,
  output word_t      lo,
  output logic       div_zero,
  output logic       unsupported
);

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

  muldiv_state_t state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [63:0]   acc_q, acc_d;
  word_t         mcand_q, mcand_d;
  logic          neg_res_q, neg_res_d;
  word_t         hi_q, hi_d, lo_q, lo_d;
  logic          done_q, done_d;
  logic          div_zero_q, div_zero_d;
  logic          is_div_op, is_signed_op;
  word_t         a_mag, b_mag;
  logic [32:0]   sum;
`ifdef MULDIV_DIVIDE_EN
  logic          is_div_q, is_div_d;
  logic          neg_rem_q, neg_rem_d;
  word_t         rem_q, rem_d;
  logic [32:0]   shifted, diff;
`else
  logic          unsupported_q, unsupported_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    neg_res_d    = neg_res_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    div_zero_d   = 1'b0;
    is_div_op    = (md_op == DIV) || (md_op == DIVU);
    is_signed_op = (md_op == MULT) || (md_op == DIV);
    a_mag        = (is_signed_op && port_a[31]) ? (~port_a + 32'd1) : port_a;
    b_mag        = (is_signed_op && port_b[31]) ? (~port_b + 32'd1) : port_b;
    sum          = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? mcand_q : 32'd0)};
`ifdef MULDIV_DIVIDE_EN
    is_div_d     = is_div_q;
    neg_rem_d    = neg_rem_q;
    rem_d        = rem_q;
    shifted      = {rem_q, acc_q[31]};
    diff         = shifted - {1'b0, mcand_q};
`else
    unsupported_d = 1'b0;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          neg_res_d = is_signed_op & (port_a[31] ^ port_b[31]);
          cnt_d     = 5'(MULDIV_ITERS - 1);
`ifdef MULDIV_DIVIDE_EN
          is_div_d  = is_div_op;
          neg_rem_d = is_signed_op & port_a[31];
`endif
          if (!is_div_op) begin
            mcand_d = a_mag;
            acc_d   = {32'd0, b_mag};
            state_d = CALC;
          end else begin
`ifdef MULDIV_DIVIDE_EN
            if (port_b == 32'd0) begin
              // raw dividend to HI, all-ones quotient, no iterations
              state_d    = DONE;
              div_zero_d = 1'b1;
              hi_d       = port_a;
              lo_d       = 32'hFFFF_FFFF;
            end else begin
              mcand_d = b_mag;
              acc_d   = {32'd0, a_mag};
              rem_d   = 32'd0;
              state_d = CALC;
            end
`else
            state_d       = DONE;
            unsupported_d = 1'b1;
`endif
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = FIX;
`ifdef MULDIV_DIVIDE_EN
        // dividend shifts out of acc[31:0] while quotient bits shift in
        if (is_div_q) begin
          if (!diff[32]) begin
            rem_d        = diff[31:0];
            acc_d[31:0]  = {acc_q[30:0], 1'b1};
          end else begin
            rem_d        = shifted[31:0];
            acc_d[31:0]  = {acc_q[30:0], 1'b0};
          end
        end else
`endif
        acc_d = {sum, acc_q[31:1]};
      end
      FIX: begin
        state_d = DONE;
`ifdef MULDIV_DIVIDE_EN
        if (is_div_q) begin
          lo_d = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
          hi_d = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
        end else
`endif
        {hi_d, lo_d} = cond_neg64(acc_q, neg_res_q);
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q       <= IDLE;
      cnt_q         <= 5'd0;
      acc_q         <= 64'd0;
      mcand_q       <= 32'd0;
      neg_res_q     <= 1'b0;
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
      done_q        <= 1'b0;
      div_zero_q    <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
      is_div_q      <= 1'b0;
      neg_rem_q     <= 1'b0;
      rem_q         <= 32'd0;
`else
      unsupported_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      mcand_q       <= mcand_d;
      neg_res_q     <= neg_res_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      done_q        <= done_d;
      div_zero_q    <= div_zero_d;
`ifdef MULDIV_DIVIDE_EN
      is_div_q      <= is_div_d;
      neg_rem_q     <= neg_rem_d;
      rem_q         <= rem_d;
`else
      unsupported_q <= unsupported_d;
`endif
    end
  end

  assign busy     = (state_q == CALC) || (state_q == FIX);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;
`ifdef MULDIV_DIVIDE_EN
  assign unsupported = 1'b0;
`else
  assign unsupported = unsupported_q;
`endif

endmodule
